axil_bram_port_ctrl: RTL and testbench
======================================

# axil_bram_port_ctrl

AXI4-Lite slave controller that owns the single port of an on-chip MMIO BRAM and arbitrates the port between write (AW+W) and read (AR) transactions. Sits between the MMIO AXI interconnect master port and the BRAM primitive, and replaces direct AXI-to-BRAM wiring. It serialises accesses, arbitrates round-robin, flags out-of-range addresses, and keeps per-direction completion counters for ILA debug.

## Interface
- ADDR_W, 32, AXI address width
- DATA_W, 32, AXI/BRAM data width (multiple of 8)
- BRAM_AW, 10, BRAM word-address width (depth = 2^BRAM_AW words)
- CNT_W, 16, completion counter width
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset; asynchronous, active-high
- awvalid/awready  in/out  1  write-address handshake; awaddr  in  ADDR_W
- wvalid/wready  in/out  1  write-data handshake; wdata  in  DATA_W; wstrb  in  DATA_W/8
- bvalid/bready  out/in  1  write response; bresp  out  2
- arvalid/arready  in/out  1  read-address handshake; araddr  in  ADDR_W
- rvalid/rready  out/in  1  read response; rdata  out  DATA_W; rresp  out  2
- bram_en  out  1  port enable; bram_we  out  DATA_W/8  byte write enables
- bram_addr  out  BRAM_AW  word address; bram_wdata  out  DATA_W; bram_rdata  in  DATA_W  (1-cycle read latency)
- wr_count, rd_count  out  CNT_W  completed write/read responses
- busy  out  1  state != IDLE

## Operation
- States: IDLE, WR_EXEC, RD_EXEC, RD_WAIT, B_RESP, R_RESP.
- IDLE: wr_req = awvalid & wvalid; rd_req = arvalid. Single request: grant it. Both: grant per prio bit (0 = write, 1 = read). After any grant, prio points to the other direction. prio resets to 0.
- awready = wready = (IDLE & write granted); arready = (IDLE & read granted). AW and W are always accepted in the same cycle; AW alone or W alone is never accepted.
- Word index = addr[BRAM_AW+1:2] (byte address, DATA_W=32 case; generally log2(DATA_W/8) low bits dropped). In range iff addr >> (BRAM_AW + log2(DATA_W/8)) == 0.
- Write grant, in range: latch address, data, and strobes -> WR_EXEC (bram_en=1, bram_we=wstrb) -> B_RESP, bresp=OKAY(00).
- Write grant, out of range: no BRAM access -> B_RESP, bresp=SLVERR(10).
- Read grant, in range: -> RD_EXEC (bram_en=1, bram_we=0) -> RD_WAIT (capture bram_rdata into rdata) -> R_RESP, rresp=OKAY.
- Read grant, out of range: -> R_RESP, rdata=0, rresp=SLVERR.
- B_RESP/R_RESP: hold valid and payload stable until ready, then IDLE. On that handshake, wr_count/rd_count increments, wrapping 2^CNT_W-1 -> 0.
- One transaction outstanding at a time; no new handshake is accepted outside IDLE.

## Timing
- Accept cycle T. In-range write: BRAM write at T+1, bvalid from T+2. In-range read: bram_en at T+1, rvalid/rdata from T+3. Out-of-range: response valid from T+1.
- bram_* outputs are registered. bram_en is high exactly one cycle per in-range access and never during out-of-range transactions.
- Earliest next accept is the cycle after the response handshake, so back-to-back writes have a minimum period of 3 cycles when bready is held high.
- Reset values: all readys, bvalid, rvalid, bram_en, bram_we, busy = 0; bresp, rresp, rdata, bram_addr, bram_wdata = 0; counters = 0; prio = 0; state = IDLE.
- Reset asserted mid-transaction: outputs go to reset values immediately and asynchronously. The pending response is dropped and no BRAM write completes after reset is asserted.

## Structure
- Package axil_bram_pkg: state enum, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, and a byte-offset helper constant derived from DATA_W.
- One sub-module, rr_arb2: a 2-requester round-robin arbiter with a prio flip-flop, giving grant and update-on-accept. Everything else lives in the top FSM.

## Test plan
- Single write 0x0000_0010 = 0xDEAD_BEEF, wstrb=F, then read 0x10 -> bram_we=F, bram_addr=4 at T+1; bvalid at T+2; rdata=0xDEADBEEF, rresp=00 at T+3.
- wstrb=4'b0011 write of 0x1234_5678 over 0xFFFF_FFFF -> readback 0xFFFF_5678.
- awvalid, wvalid, and arvalid all held high together from reset -> grant order W, R, W, R. wr_count and rd_count each increment by 1 per response.
- Write and read at byte address 0x1000 (BRAM_AW=10) -> bresp/rresp=10, rdata=0, bram_en never asserted, response at T+1.
- awvalid high without wvalid for 5 cycles -> awready stays 0. Then assert wvalid -> both readies pulse together for one cycle.
- Hold bready low for 4 cycles, then assert rst during B_RESP -> bvalid=0 immediately. After reset release, the next read returns OKAY and the counters read 0.

Source files
------------

// File: rtl/axil_bram_pkg.sv
// Shared types and constants for the AXI4-Lite BRAM port controller.
package axil_bram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_EXEC,
    ST_RD_EXEC,
    ST_RD_WAIT,
    ST_B_RESP,
    ST_R_RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Number of low address bits that select a byte within one data word.
  function automatic int byte_off(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; req[0] = write, req[1] = read.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic prio_q, prio_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

  always_comb begin
    gnt_o  = 2'b00;
    prio_d = prio_q;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
    // Any accepted grant hands priority to the other direction.
    if (accept_i && (gnt_o != 2'b00)) prio_d = gnt_o[0];
  end

endmodule

// File: rtl/axil_bram_port_ctrl.sv
// AXI4-Lite slave owning a single-port BRAM; serialises write and read
// transactions with round-robin arbitration and range checking.
//   state      | meaning
//   IDLE       | waiting for a request, readies may be asserted
//   WR_EXEC    | registered BRAM write cycle
//   RD_EXEC    | registered BRAM read enable cycle
//   RD_WAIT    | BRAM read data returning, captured into rdata
//   B_RESP     | write response held until bready
//   R_RESP     | read response held until rready
module axil_bram_port_ctrl
  import axil_bram_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BRAM_AW = 10,
  parameter int CNT_W   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [ADDR_W-1:0]     awaddr_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   wstrb_i,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  output logic [1:0]            bresp_o,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  input  logic [ADDR_W-1:0]     araddr_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [DATA_W-1:0]     rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  bram_en_o,
  output logic [DATA_W/8-1:0]   bram_we_o,
  output logic [BRAM_AW-1:0]    bram_addr_o,
  output logic [DATA_W-1:0]     bram_wdata_o,
  input  logic [DATA_W-1:0]     bram_rdata_i,
  output logic [CNT_W-1:0]      wr_count_o,
  output logic [CNT_W-1:0]      rd_count_o,
  output logic                  busy_o
);

  localparam int OFF    = byte_off(DATA_W);
  localparam int STRB_W = DATA_W / 8;

  state_e              state_q, state_d;
  logic                bram_en_q, bram_en_d;
  logic [STRB_W-1:0]   bram_we_q, bram_we_d;
  logic [BRAM_AW-1:0]  bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0]   bram_wdata_q, bram_wdata_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    wr_count_q, wr_count_d;
  logic [CNT_W-1:0]    rd_count_q, rd_count_d;

  logic                idle;
  logic [1:0]          req;
  logic [1:0]          gnt;
  logic                wr_in_rng;
  logic                rd_in_rng;
  logic [BRAM_AW-1:0]  aw_idx;
  logic [BRAM_AW-1:0]  ar_idx;

  assign idle = (state_q == ST_IDLE);
  assign req  = idle ? {arvalid_i, awvalid_i & wvalid_i} : 2'b00;

  rr_arb2 u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req),
    .accept_i (idle),
    .gnt_o    (gnt)
  );

  assign wr_in_rng = ((awaddr_i >> (BRAM_AW + OFF)) == '0);
  assign rd_in_rng = ((araddr_i >> (BRAM_AW + OFF)) == '0);
  assign aw_idx    = awaddr_i[BRAM_AW+OFF-1:OFF];
  assign ar_idx    = araddr_i[BRAM_AW+OFF-1:OFF];

  // Readies are combinational from the grant, so hold them low while in reset.
  assign awready_o = gnt[0] & ~rst_i;
  assign wready_o  = gnt[0] & ~rst_i;
  assign arready_o = gnt[1] & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      bram_en_q    <= 1'b0;
      bram_we_q    <= '0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      bresp_q      <= RESP_OKAY;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= '0;
      wr_count_q   <= '0;
      rd_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      bram_en_q    <= bram_en_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
      bresp_q      <= bresp_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
      wr_count_q   <= wr_count_d;
      rd_count_q   <= rd_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bram_en_d    = 1'b0;
    bram_we_d    = '0;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    bresp_d      = bresp_q;
    rresp_d      = rresp_q;
    rdata_d      = rdata_q;
    wr_count_d   = wr_count_q;
    rd_count_d   = rd_count_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt[0]) begin
          if (wr_in_rng) begin
            state_d      = ST_WR_EXEC;
            bram_en_d    = 1'b1;
            bram_we_d    = wstrb_i;
            bram_addr_d  = aw_idx;
            bram_wdata_d = wdata_i;
            bresp_d      = RESP_OKAY;
          end else begin
            state_d = ST_B_RESP;
            bresp_d = RESP_SLVERR;
          end
        end else if (gnt[1]) begin
          if (rd_in_rng) begin
            state_d     = ST_RD_EXEC;
            bram_en_d   = 1'b1;
            bram_addr_d = ar_idx;
            rresp_d     = RESP_OKAY;
          end else begin
            state_d = ST_R_RESP;
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
        end
      end
      ST_WR_EXEC: state_d = ST_B_RESP;
      ST_RD_EXEC: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        rdata_d = bram_rdata_i;
        state_d = ST_R_RESP;
      end
      ST_B_RESP: begin
        if (bready_i) begin
          state_d    = ST_IDLE;
          wr_count_d = wr_count_q + 1'b1;
        end
      end
      ST_R_RESP: begin
        if (rready_i) begin
          state_d    = ST_IDLE;
          rd_count_d = rd_count_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bvalid_o     = (state_q == ST_B_RESP);
  assign rvalid_o     = (state_q == ST_R_RESP);
  assign bresp_o      = bresp_q;
  assign rresp_o      = rresp_q;
  assign rdata_o      = rdata_q;
  assign bram_en_o    = bram_en_q;
  assign bram_we_o    = bram_we_q;
  assign bram_addr_o  = bram_addr_q;
  assign bram_wdata_o = bram_wdata_q;
  assign wr_count_o   = wr_count_q;
  assign rd_count_o   = rd_count_q;
  assign busy_o       = ~idle;

endmodule

// File: tb/tb_axil_bram_port_ctrl.sv
// Directed bench for axil_bram_port_ctrl with a response scoreboard and BRAM model.
module tb_axil_bram_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata, bram_wdata, bram_rdata;
  logic [3:0]  wstrb, bram_we;
  logic [1:0]  bresp, rresp;
  logic        bram_en, busy;
  logic [9:0]  bram_addr;
  logic [15:0] wr_count, rd_count;

  always #5 clk = ~clk;

  axil_bram_port_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr),
    .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wstrb_i(wstrb),
    .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp),
    .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr),
    .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rresp_o(rresp),
    .bram_en_o(bram_en), .bram_we_o(bram_we), .bram_addr_o(bram_addr),
    .bram_wdata_o(bram_wdata), .bram_rdata_i(bram_rdata),
    .wr_count_o(wr_count), .rd_count_o(rd_count), .busy_o(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // BRAM model: 1-cycle read latency, byte write enables
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_wdata[b*8 +: 8];
      bram_rdata <= mem[bram_addr];
    end
  end

  // Scoreboard
  typedef struct {
    bit          is_rd;
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_push, e_pop;
  logic [31:0] ref_mem [1024];
  int          cyc = 0;
  int          en_cnt = 0;
  int          first_b, first_r;
  bit          seen_b, seen_r;
  logic [15:0] wr_model, rd_model;
  logic [31:0] last_rdata;
  bit          in_rng;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bram_en) en_cnt++;
    if (rst) begin
      seen_b   = 0;
      seen_r   = 0;
      wr_model = '0;
      rd_model = '0;
    end else begin
      if (awvalid && wvalid && awready && wready) begin
        in_rng       = ((awaddr >> 12) == 0);
        e_push.is_rd = 0;
        e_push.resp  = in_rng ? 2'b00 : 2'b10;
        e_push.data  = '0;
        e_push.lat   = in_rng ? 2 : 1;
        e_push.acc   = cyc;
        exp_q.push_back(e_push);
        if (in_rng)
          for (int b = 0; b < 4; b++)
            if (wstrb[b]) ref_mem[awaddr[11:2]][b*8 +: 8] = wdata[b*8 +: 8];
      end
      if (arvalid && arready) begin
        in_rng       = ((araddr >> 12) == 0);
        e_push.is_rd = 1;
        e_push.resp  = in_rng ? 2'b00 : 2'b10;
        e_push.data  = in_rng ? ref_mem[araddr[11:2]] : 32'h0;
        e_push.lat   = in_rng ? 3 : 1;
        e_push.acc   = cyc;
        exp_q.push_back(e_push);
      end
      if (bvalid && !seen_b) begin seen_b = 1; first_b = cyc; end
      if (rvalid && !seen_r) begin seen_r = 1; first_r = cyc; end
      if (bvalid && bready) begin
        seen_b = 0;
        chk("b_pending", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e_pop = exp_q.pop_front();
          chk("b_kind", 64'(e_pop.is_rd), 0);
          chk("bresp", bresp, e_pop.resp);
          chk("b_latency", 64'(first_b - e_pop.acc), 64'(e_pop.lat));
        end
        chk("wr_count", wr_count, wr_model);
        wr_model = wr_model + 16'd1;
      end
      if (rvalid && rready) begin
        seen_r = 0;
        last_rdata = rdata;
        chk("r_pending", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e_pop = exp_q.pop_front();
          chk("r_kind", 64'(e_pop.is_rd), 1);
          chk("rresp", rresp, e_pop.resp);
          chk("rdata", rdata, e_pop.data);
          chk("r_latency", 64'(first_r - e_pop.acc), 64'(e_pop.lat));
        end
        chk("rd_count", rd_count, rd_model);
        rd_model = rd_model + 16'd1;
      end
    end
  end

  task automatic wait_acc(input bit is_rd);
    int n = 0;
    #1;
    while (!(is_rd ? arready : (awready && wready)) && n < 50) begin
      @(posedge clk); #2; n++;
    end
    chk("accept_timeout", 64'(n < 50), 1);
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    wait_acc(0);
    awvalid = 0; wvalid = 0;
  endtask

  task automatic rd(input logic [31:0] a);
    araddr = a; arvalid = 1;
    wait_acc(1);
    arvalid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin @(posedge clk); #1; n++; end
    chk("idle_timeout", 64'(n < 50), 1);
  endtask

  initial begin
    logic [3:0] g;
    int ng, n, en_before;
    for (int i = 0; i < 1024; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    rst = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    g = '0;
    #3;
    chk("rst_ctrl", {awready, wready, arready, bvalid, rvalid, bram_en, busy}, 0);
    chk("rst_bram", {bram_we, bram_addr, bram_wdata}, 0);
    chk("rst_resp", {bresp, rresp, rdata}, 0);
    chk("rst_counts", {wr_count, rd_count}, 0);
    @(posedge clk); #1;
    rst = 0;

    // All three valids held from reset: grants alternate W, R, W, R
    awaddr = 32'h20; wdata = 32'hA5A5_0001; wstrb = 4'hF; araddr = 32'h20;
    awvalid = 1; wvalid = 1; arvalid = 1;
    ng = 0; n = 0;
    while (ng < 4 && n < 60) begin
      #1;
      if (awready && wready) begin g[ng] = 1'b0; ng++; end
      else if (arready) begin g[ng] = 1'b1; ng++; end
      @(posedge clk); #1; n++;
    end
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("grant_count", 64'(ng), 4);
    chk("grant_order", g, 4'b1010);
    wait_idle();
    chk("rr_wr_count", wr_count, 2);
    chk("rr_rd_count", rd_count, 2);

    // Full-word write then readback
    wr(32'h10, 32'hDEAD_BEEF, 4'hF);
    chk("wr_bram_en", bram_en, 1);
    chk("wr_bram_we", bram_we, 4'hF);
    chk("wr_bram_addr", bram_addr, 10'd4);
    chk("wr_bram_wdata", bram_wdata, 32'hDEAD_BEEF);
    wait_idle();
    rd(32'h10);
    chk("rd_bram_en", bram_en, 1);
    chk("rd_bram_we", bram_we, 4'h0);
    wait_idle();
    chk("rd_deadbeef", last_rdata, 32'hDEAD_BEEF);

    // Partial strobe merge
    wr(32'h30, 32'hFFFF_FFFF, 4'hF); wait_idle();
    wr(32'h30, 32'h1234_5678, 4'b0011); wait_idle();
    rd(32'h30); wait_idle();
    chk("strb_merge", last_rdata, 32'hFFFF_5678);

    // Out-of-range accesses: SLVERR, no BRAM enable
    en_before = en_cnt;
    wr(32'h1000, 32'h0BAD_0BAD, 4'hF); wait_idle();
    rd(32'h1000); wait_idle();
    chk("oor_rdata", last_rdata, 0);
    chk("oor_no_bram", 64'(en_cnt), 64'(en_before));

    // AW without W is never accepted
    awaddr = 32'h50; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("aw_alone", {awready, wready}, 2'b00);
      @(posedge clk); #1;
    end
    wvalid = 1; #1;
    chk("aw_w_pulse", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    chk("aw_w_after", {awready, wready}, 2'b00);
    awvalid = 0; wvalid = 0;
    wait_idle();

    // Reset during a stalled write response
    bready = 0;
    wr(32'h40, 32'h0000_0055, 4'hF);
    n = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    chk("b_stall_timeout", 64'(n < 20), 1);
    for (int i = 0; i < 4; i++) begin
      chk("b_hold", {bvalid, bresp}, 3'b100);
      @(posedge clk); #1;
    end
    rst = 1; #1;
    chk("rst_async_b", {bvalid, busy, bram_en}, 3'b000);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 0; bready = 1;
    chk("post_rst_counts", {wr_count, rd_count}, 0);
    rd(32'h40); wait_idle();
    chk("post_rst_read", last_rdata, 32'h0000_0055);
    chk("post_rst_rdcnt", {wr_count, rd_count}, {16'd0, 16'd1});

    @(posedge clk); #1;
    chk("sb_empty", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
